// File: rtl/elastic_alu_buffered.sv
// Elastic ALU for the CGRA processing element: joins SELF-protocol operand channels,
// runs one variable-latency operation at a time and queues results in a small FIFO.
module elastic_alu_buffered #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned OP_WIDTH      = 4,
  parameter int unsigned NUM_INPUTS    = 2,
  parameter int unsigned OUT_DEPTH     = 2,
  parameter int unsigned ADD_LAT       = 1,
  parameter int unsigned MUL_LAT       = 3,
  parameter int unsigned DIV_LAT       = 8,
  parameter int unsigned LOAD_LAT      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    input_data [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0]    valid_input,
  output logic [NUM_INPUTS-1:0]    stop_input,
  input  logic [OP_WIDTH-1:0]      op,
  input  logic [DATA_WIDTH-1:0]    const_data,
  output logic [DATA_WIDTH-1:0]    output_data,
  output logic                     valid_output,
  input  logic                     stop_output,
  output logic [ADDRESS_WIDTH-1:0] memory_read_address,
  input  logic [DATA_WIDTH-1:0]    memory_read_data,
  output logic                     memory_write,
  output logic [ADDRESS_WIDTH-1:0] memory_write_address,
  output logic [DATA_WIDTH-1:0]    memory_write_data,
  output logic                     switch_context
);

  localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_CONST = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_OUT   = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_ROUTE = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(9);

  localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned MAX_DL  = (DIV_LAT > LOAD_LAT) ? DIV_LAT : LOAD_LAT;
  localparam int unsigned MAX_LAT = (MAX_AM > MAX_DL) ? MAX_AM : MAX_DL;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned OCC_W   = $clog2(OUT_DEPTH + 1);
  localparam int unsigned PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [OP_WIDTH-1:0]     op_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q, c_q;
  logic [DATA_WIDTH-1:0]   buf_mem [OUT_DEPTH];
  logic [PTR_W-1:0]        head, tail;
  logic [OCC_W-1:0]        count;

  logic                    req0, req1, op_valid, ready, fire, push, pop;
  int unsigned             fire_lat;
  logic [OP_WIDTH-1:0]     sel_op;
  logic [DATA_WIDTH-1:0]   sel_a, sel_b, sel_c, result;
  logic                    unused_inputs;

  function automatic int unsigned op_latency(input logic [OP_WIDTH-1:0] o);
    case (o)
      OP_MUL:  return MUL_LAT;
      OP_DIV:  return DIV_LAT;
      OP_LOAD: return LOAD_LAT;
      default: return ADD_LAT;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] compute(
    input logic [OP_WIDTH-1:0]   o,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] c,
    input logic [DATA_WIDTH-1:0] rd
  );
    case (o)
      OP_ADD:         return a + b;
      OP_SUB:         return a - b;
      OP_MUL:         return a * b;
      OP_DIV:         return (b == '0) ? '1 : a / b;
      OP_CONST:       return c;
      OP_LOAD:        return rd;
      OP_OUT, OP_ROUTE: return a;
      OP_STORE:       return b;
      default:        return '0;
    endcase
  endfunction

  always_comb begin
    req0     = 1'b0;
    req1     = 1'b0;
    op_valid = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_STORE: begin
        req0 = 1'b1;
        req1 = 1'b1;
      end
      OP_LOAD, OP_OUT, OP_ROUTE: req0 = 1'b1;
      OP_CONST: ;
      default: op_valid = 1'b0;
    endcase
  end

  assign fire_lat = op_latency(op);
  // In IDLE nothing is in flight, so occupancy is just the buffered count.
  assign ready    = (state == IDLE) && (count < OCC_W'(OUT_DEPTH)) && op_valid;
  assign fire     = ready && (!req0 || valid_input[0]) && (!req1 || valid_input[1]);

  always_comb begin
    unused_inputs = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) stop_input[i] = 1'b1;
    stop_input[0] = !(req0 && fire);
    stop_input[1] = !(req1 && fire);
    for (int unsigned i = 2; i < NUM_INPUTS; i++)
      unused_inputs = unused_inputs ^ (^input_data[i]) ^ valid_input[i];
  end

  // Single-cycle ops complete at the fire edge straight from the live inputs;
  // longer ops complete from the latched copies.
  always_comb begin
    if (state == IDLE) begin
      sel_op = op;
      sel_a  = input_data[0];
      sel_b  = input_data[1];
      sel_c  = const_data;
    end else begin
      sel_op = op_q;
      sel_a  = a_q;
      sel_b  = b_q;
      sel_c  = c_q;
    end
    result = compute(sel_op, sel_a, sel_b, sel_c, memory_read_data);
  end

  assign push           = (fire && (fire_lat == 1)) || ((state == BUSY) && (cnt == CNT_W'(1)));
  assign valid_output   = (count != '0);
  assign pop            = valid_output && !stop_output;
  assign switch_context = pop;
  assign output_data    = valid_output ? buf_mem[head] : '0;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (fire && (fire_lat > 1)) begin
          state_next = BUSY;
          cnt_next   = CNT_W'(fire_lat - 1);
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q                 <= '0;
      a_q                  <= '0;
      b_q                  <= '0;
      c_q                  <= '0;
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      memory_write         <= 1'b0;
      memory_write_address <= '0;
      memory_write_data    <= '0;
      memory_read_address  <= '0;
    end else begin
      memory_write <= fire && (op == OP_STORE);
      if (fire) begin
        op_q <= op;
        a_q  <= input_data[0];
        b_q  <= input_data[1];
        c_q  <= const_data;
        if (op == OP_STORE) begin
          memory_write_address <= input_data[0][ADDRESS_WIDTH-1:0];
          memory_write_data    <= input_data[1];
        end
        if (op == OP_LOAD) memory_read_address <= input_data[0][ADDRESS_WIDTH-1:0];
      end
      if (push) tail <= (tail == PTR_W'(OUT_DEPTH - 1)) ? '0 : tail + PTR_W'(1);
      if (pop)  head <= (head == PTR_W'(OUT_DEPTH - 1)) ? '0 : head + PTR_W'(1);
      count <= count + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[tail] <= result;
  end

endmodule

// File: tb/tb_elastic_alu_buffered.sv
// Bench for elastic_alu_buffered: directed literal cases plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_elastic_alu_buffered;
  localparam int DW = 32, AW = 16, OW = 4, NI = 3, DEPTH = 2;
  localparam int ADD_L = 1, MUL_L = 3, DIV_L = 8, LOAD_L = 2;

  logic          clk, reset;
  logic [DW-1:0] input_data [NI];
  logic [NI-1:0] valid_input, stop_input;
  logic [OW-1:0] op;
  logic [DW-1:0] const_data, output_data, memory_read_data, memory_write_data;
  logic          valid_output, stop_output, memory_write, switch_context;
  logic [AW-1:0] memory_read_address, memory_write_address;

  elastic_alu_buffered #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .OP_WIDTH(OW), .NUM_INPUTS(NI), .OUT_DEPTH(DEPTH),
    .ADD_LAT(ADD_L), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .LOAD_LAT(LOAD_L)
  ) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .valid_input(valid_input),
    .stop_input(stop_input), .op(op), .const_data(const_data), .output_data(output_data),
    .valid_output(valid_output), .stop_output(stop_output),
    .memory_read_address(memory_read_address), .memory_read_data(memory_read_data),
    .memory_write(memory_write), .memory_write_address(memory_write_address),
    .memory_write_data(memory_write_data), .switch_context(switch_context)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory, 256 words aliased on the low address byte.
  logic          init_mem;
  logic [DW-1:0] phys [256];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) phys[i] <= 32'hC0DE0000 | 32'(i);
    end else if (memory_write) begin
      phys[memory_write_address[7:0]] <= memory_write_data;
    end
  end
  assign memory_read_data = phys[memory_read_address[7:0]];

  int passed = 0, total = 0;

  // Behavioural model state
  logic [DW-1:0] q [$];
  int            busy_rem = 0;
  logic [DW-1:0] pend;
  bit            mw_exp = 0, ld_fl = 0;
  logic [AW-1:0] mwa_exp, mra_exp;
  logic [DW-1:0] mwd_exp;
  logic [DW-1:0] model_mem [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int lat_of(input logic [OW-1:0] o);
    case (o)
      4'd3:    return MUL_L;
      4'd4:    return DIV_L;
      4'd6:    return LOAD_L;
      default: return ADD_L;
    endcase
  endfunction

  function automatic logic [DW-1:0] res_of(input logic [OW-1:0] o, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW-1:0] c,
                                           input logic [DW-1:0] m);
    logic [63:0] p;
    case (o)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: begin p = 64'(a) * 64'(b); return p[31:0]; end
      4'd4: return (b == 0) ? 32'hFFFFFFFF : a / b;
      4'd5: return c;
      4'd6: return m;
      4'd7, 4'd8: return a;
      default: return b;
    endcase
  endfunction

  // One clock: check DUT against the model at the falling edge, advance the model
  // with the inputs the rising edge will see, then return just after that edge.
  task automatic cycle();
    bit            ev, r0, r1, opv, rdy, fire;
    logic [DW-1:0] a, b, r;
    @(negedge clk);
    if (reset) begin
      q.delete();
      busy_rem = 0;
      mw_exp   = 0;
      ld_fl    = 0;
    end else begin
      ev   = q.size() > 0;
      opv  = (op >= 4'd1) && (op <= 4'd9);
      r1   = (op >= 4'd1 && op <= 4'd4) || op == 4'd9;
      r0   = r1 || op == 4'd6 || op == 4'd7 || op == 4'd8;
      rdy  = busy_rem == 0 && q.size() < DEPTH && opv;
      fire = rdy && (!r0 || valid_input[0]) && (!r1 || valid_input[1]);
      chk("valid_output", valid_output, ev);
      if (ev) chk("output_data", output_data, q[0]);
      chk("switch_context", switch_context, ev && !stop_output);
      chk("stop_input", stop_input, {1'b1, !(r1 && fire), !(r0 && fire)});
      chk("memory_write", memory_write, mw_exp);
      if (mw_exp) begin
        chk("memory_write_address", memory_write_address, mwa_exp);
        chk("memory_write_data", memory_write_data, mwd_exp);
      end
      if (ld_fl) chk("memory_read_address", memory_read_address, mra_exp);

      mw_exp = 0;
      if (ev && !stop_output) void'(q.pop_front());
      if (fire) begin
        a = input_data[0];
        b = input_data[1];
        r = res_of(op, a, b, const_data, model_mem[a[7:0]]);
        if (op == 4'd9) begin
          model_mem[a[7:0]] = b;
          mw_exp  = 1;
          mwa_exp = a[AW-1:0];
          mwd_exp = b;
        end
        if (op == 4'd6) begin
          mra_exp = a[AW-1:0];
          ld_fl   = lat_of(op) > 1;
        end
        if (lat_of(op) == 1) q.push_back(r);
        else begin
          busy_rem = lat_of(op) - 1;
          pend     = r;
        end
      end else if (busy_rem > 0) begin
        busy_rem--;
        if (busy_rem == 0) begin
          q.push_back(pend);
          ld_fl = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one op into an idle, empty block and measure its result latency.
  task automatic run_op(input logic [OW-1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] expv, input int explat,
                        input string nm);
    int n;
    op = o; input_data[0] = a; input_data[1] = b; const_data = c;
    valid_input = '1; stop_output = 1'b0;
    cycle();
    op = '0; valid_input = '0;
    n = 1;
    while (!valid_output && n < 40) begin
      cycle();
      n++;
    end
    chk({nm, "_latency"}, n, explat);
    chk({nm, "_data"}, output_data, expv);
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 32'hC0DE0000 | 32'(i);
    reset = 1'b1; init_mem = 1'b1; op = '0; const_data = '0; stop_output = 1'b0;
    valid_input = '0;
    for (int i = 0; i < NI; i++) input_data[i] = '0;
    cycle();
    init_mem = 1'b0;
    cycle();
    reset = 1'b0;

    chk("rst_valid_output", valid_output, 0);
    chk("rst_output_data", output_data, 0);
    chk("rst_switch_context", switch_context, 0);
    chk("rst_memory_write", memory_write, 0);
    chk("rst_read_address", memory_read_address, 0);
    chk("rst_write_address", memory_write_address, 0);
    chk("rst_write_data", memory_write_data, 0);
    chk("rst_stop_input", stop_input, 3'b111);

    // add 5 + 7, then a back-to-back add the very next cycle
    op = 4'd1; input_data[0] = 32'd5; input_data[1] = 32'd7; valid_input = 3'b011;
    cycle();
    chk("add_data", output_data, 32'd12);
    chk("add_valid", valid_output, 1);
    chk("add_switch_context", switch_context, 1);
    chk("add_next_accepted", stop_input[0], 0);
    cycle();
    op = '0; valid_input = '0;
    cycle(); cycle();

    // mul overflow to zero, busy for MUL_LAT-1 cycles
    op = 4'd3; input_data[0] = 32'h10000; input_data[1] = 32'h10000; valid_input = 3'b011;
    cycle();
    chk("mul_stop_c1", stop_input[0], 1);
    cycle();
    chk("mul_stop_c2", stop_input[0], 1);
    op = '0; valid_input = '0;
    cycle();
    chk("mul_valid", valid_output, 1);
    chk("mul_data", output_data, 32'h0);
    cycle();

    run_op(4'd4, 32'd9, 32'd0, 32'd0, 32'hFFFFFFFF, DIV_L, "div_by_zero");
    run_op(4'd2, 32'd3, 32'd5, 32'd0, 32'hFFFFFFFE, ADD_L, "sub_wrap");
    run_op(4'd4, 32'd100, 32'd7, 32'd0, 32'd14, DIV_L, "div_plain");

    // Full buffer: third route stalls until one cycle after the first pop
    stop_output = 1'b1; op = 4'd8; valid_input = 3'b001; input_data[0] = 32'd1;
    cycle();
    input_data[0] = 32'd2;
    cycle();
    input_data[0] = 32'd3;
    chk("full_stall", stop_input[0], 1);
    cycle(); cycle();
    chk("full_hold_data", output_data, 32'd1);
    chk("full_hold_stall", stop_input[0], 1);
    stop_output = 1'b0;
    chk("pop1_data", output_data, 32'd1);
    chk("pop1_no_bypass", stop_input[0], 1);
    cycle();
    chk("pop2_data", output_data, 32'd2);
    chk("third_fires", stop_input[0], 0);
    cycle();
    op = '0; valid_input = '0;
    chk("pop3_data", output_data, 32'd3);
    cycle(); cycle();

    // store then load back through the attached memory
    op = 4'd9; input_data[0] = 32'h20; input_data[1] = 32'hAB; valid_input = 3'b011;
    cycle();
    op = '0; valid_input = '0;
    chk("store_strobe", memory_write, 1);
    chk("store_address", memory_write_address, 16'h20);
    chk("store_data", memory_write_data, 32'hAB);
    chk("store_result", output_data, 32'hAB);
    cycle();
    chk("store_strobe_once", memory_write, 0);
    run_op(4'd6, 32'h20, 32'd0, 32'd0, 32'hAB, LOAD_L, "load");

    // const needs no channel
    op = 4'd5; valid_input = '0; const_data = 32'h1234;
    chk("const_stops", stop_input, 3'b111);
    cycle();
    op = '0;
    chk("const_valid", valid_output, 1);
    chk("const_data", output_data, 32'h1234);
    cycle();

    // reset while a div is in flight
    op = 4'd4; input_data[0] = 32'd100; input_data[1] = 32'd7; valid_input = 3'b011;
    cycle();
    op = '0; valid_input = '0;
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midrst_valid", valid_output, 0);
    chk("midrst_stop", stop_input, 3'b111);
    repeat (10) cycle();
    chk("midrst_no_result", valid_output, 0);
    run_op(4'd1, 32'd1, 32'd2, 32'd0, 32'd3, ADD_L, "post_reset_add");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
      else op = 4'($urandom_range(1, 9));
      input_data[0] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
      input_data[1] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      input_data[2] = $urandom;
      valid_input   = 3'($urandom);
      const_data    = $urandom;
      stop_output   = ($urandom_range(0, 2) == 0);
      reset         = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
